// File: rtl/coe_load_pkg.sv
// -----------------------------------------------------------------------------
// coe_load_pkg
// Shared definitions for the coefficient load sequencer: default chain
// lengths and widths, the word-kind encoding used on in_kind, the sequencer
// FSM state type and the phase type of the strobe pulse generator.
// -----------------------------------------------------------------------------
package coe_load_pkg;

    localparam int N_INTERP_DEF = 12;
    localparam int N_PATH_DEF   = 3;
    localparam int IW_DEF       = 10;
    localparam int CW_DEF       = 16;

    localparam logic KIND_INTERP = 1'b0;
    localparam logic KIND_PATH   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        C_SETUP,
        C_STROBE
    } state_e;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_SETUP,
        PG_HIGH
    } pulse_phase_e;

endpackage

// File: rtl/coe_strobe_gen.sv
// -----------------------------------------------------------------------------
// coe_strobe_gen
// Registered setup / high / low pulse generator. A start request latches a
// mask of strobe lines; the following cycle is a low setup cycle, the cycle
// after that drives the masked lines high for exactly one cycle, then they
// return low. The strobes come straight from flops so they can be used as
// clocks downstream.
//
// Ports:
//   CLK       system clock
//   Reset     synchronous active-high reset, drops any strobe immediately
//   start_i   begin a pulse sequence (only honoured while idle)
//   mask_i    which strobe lines to pulse
//   strobe_o  registered strobe lines
// -----------------------------------------------------------------------------
module coe_strobe_gen
    import coe_load_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [WIDTH-1:0] strobe_o
);

    pulse_phase_e     phase_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] strobe_q;

    // Phase sequencer; the mask is captured at start so the caller may change
    // its inputs while the pulse is in flight.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            phase_q  <= PG_IDLE;
            mask_q   <= '0;
            strobe_q <= '0;
        end else begin
            case (phase_q)
                PG_IDLE: begin
                    if (start_i) begin
                        mask_q  <= mask_i;
                        phase_q <= PG_SETUP;
                    end
                end
                PG_SETUP: begin
                    strobe_q <= mask_q;
                    phase_q  <= PG_HIGH;
                end
                PG_HIGH: begin
                    strobe_q <= '0;
                    phase_q  <= PG_IDLE;
                end
                default: begin
                    strobe_q <= '0;
                    phase_q  <= PG_IDLE;
                end
            endcase
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/coe_load_sequencer.sv
// -----------------------------------------------------------------------------
// coe_load_sequencer
// Write-side controller for the interpolation-tap chain (sel1 / interp_coe)
// and the path-gain chain (sel2 / coe). Host words arrive over a valid/ready
// handshake and are shifted into the selected chain with a one-cycle setup
// and a one-cycle strobe. A commit request pulses sel3 and sel4 together to
// transfer the chains into their buffers and clears the counters.
//
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   in_valid / in_ready   host word handshake
//   in_kind, in_data      word kind (0 tap, 1 gain) and payload
//   commit_valid/_ready   commit handshake (ready mirrors in_ready)
//   interp_coe, coe       chain data, held until the next accepted word
//   sel1..sel4            registered shift / commit strobes
//   interp_cnt, path_cnt  words shifted since the last commit
//   err_overflow          sticky: word arrived for a full chain
//   commit_done           one-cycle pulse after the commit strobe
// -----------------------------------------------------------------------------
module coe_load_sequencer
    import coe_load_pkg::*;
#(
    parameter int N_INTERP = N_INTERP_DEF,
    parameter int N_PATH   = N_PATH_DEF,
    parameter int IW       = IW_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_kind,
    input  logic [CW-1:0] in_data,
    input  logic          commit_valid,
    output logic          commit_ready,
    output logic [IW-1:0] interp_coe,
    output logic [CW-1:0] coe,
    output logic          sel1,
    output logic          sel2,
    output logic          sel3,
    output logic          sel4,
    output logic [3:0]    interp_cnt,
    output logic [1:0]    path_cnt,
    output logic          err_overflow,
    output logic          commit_done
);

    localparam logic [3:0] INTERP_FULL = 4'(N_INTERP);
    localparam logic [1:0] PATH_FULL   = 2'(N_PATH);

    state_e        state_q;
    logic          ready_q;
    logic          kind_q;
    logic [IW-1:0] interp_coe_q;
    logic [CW-1:0] coe_q;
    logic [3:0]    interp_cnt_q;
    logic [1:0]    path_cnt_q;
    logic          err_q;
    logic          commit_done_q;

    logic          idle;
    logic          has_room;
    logic          word_go;
    logic          commit_go;
    logic [1:0]    word_mask;
    logic [1:0]    word_strobe;
    logic [1:0]    commit_strobe;

    // Handshake decode. A word always wins over a simultaneous commit, and a
    // word for a full chain is accepted but never starts a strobe.
    always_comb begin
        idle      = (state_q == IDLE);
        has_room  = (in_kind == KIND_INTERP) ? (interp_cnt_q < INTERP_FULL)
                                             : (path_cnt_q < PATH_FULL);
        word_go   = idle && in_valid && has_room;
        commit_go = idle && !in_valid && commit_valid;
        word_mask = (in_kind == KIND_INTERP) ? 2'b10 : 2'b01;
    end

    // Sequencer FSM with counters, chain data and the sticky error flag.
    // ready_q is set on the edge that enters IDLE so in_ready is a flop.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            kind_q        <= KIND_INTERP;
            interp_coe_q  <= '0;
            coe_q         <= '0;
            interp_cnt_q  <= '0;
            path_cnt_q    <= '0;
            err_q         <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            commit_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (has_room) begin
                            kind_q  <= in_kind;
                            state_q <= W_SETUP;
                            ready_q <= 1'b0;
                            if (in_kind == KIND_INTERP) begin
                                interp_coe_q <= in_data[IW-1:0];
                            end else begin
                                coe_q <= in_data;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (commit_valid) begin
                        state_q <= C_SETUP;
                        ready_q <= 1'b0;
                    end
                end
                W_SETUP: begin
                    state_q <= W_STROBE;
                    if (kind_q == KIND_INTERP) begin
                        interp_cnt_q <= interp_cnt_q + 4'd1;
                    end else begin
                        path_cnt_q <= path_cnt_q + 2'd1;
                    end
                end
                W_STROBE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                C_SETUP: begin
                    state_q <= C_STROBE;
                end
                C_STROBE: begin
                    state_q       <= IDLE;
                    ready_q       <= 1'b1;
                    interp_cnt_q  <= '0;
                    path_cnt_q    <= '0;
                    err_q         <= 1'b0;
                    commit_done_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    coe_strobe_gen #(.WIDTH(2)) u_word_strobe (
        .CLK      (CLK),
        .Reset    (Reset),
        .start_i  (word_go),
        .mask_i   (word_mask),
        .strobe_o (word_strobe)
    );

    coe_strobe_gen #(.WIDTH(2)) u_commit_strobe (
        .CLK      (CLK),
        .Reset    (Reset),
        .start_i  (commit_go),
        .mask_i   (2'b11),
        .strobe_o (commit_strobe)
    );

    assign in_ready     = ready_q;
    assign commit_ready = ready_q;
    assign interp_coe   = interp_coe_q;
    assign coe          = coe_q;
    assign sel1         = word_strobe[1];
    assign sel2         = word_strobe[0];
    assign sel3         = commit_strobe[1];
    assign sel4         = commit_strobe[0];
    assign interp_cnt   = interp_cnt_q;
    assign path_cnt     = path_cnt_q;
    assign err_overflow = err_q;
    assign commit_done  = commit_done_q;

endmodule

// File: tb/tb_coe_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_coe_load_sequencer
// Self-checking bench for coe_load_sequencer. A transaction-level model keeps
// the expected chain contents, counts and error flag; each operation predicts
// the three cycles that follow its handshake.
// -----------------------------------------------------------------------------
module tb_coe_load_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [15:0] in_data;
    logic        commit_valid;
    logic        commit_ready;
    logic [9:0]  interp_coe;
    logic [15:0] coe;
    logic        sel1, sel2, sel3, sel4;
    logic [3:0]  interp_cnt;
    logic [1:0]  path_cnt;
    logic        err_overflow;
    logic        commit_done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         expInterpCnt;
    int         expPathCnt;
    logic [9:0] expInterp;
    logic [15:0] expCoe;
    logic       expErr;

    coe_load_sequencer dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_data      (in_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .interp_coe   (interp_coe),
        .coe          (coe),
        .sel1         (sel1),
        .sel2         (sel2),
        .sel3         (sel3),
        .sel4         (sel4),
        .interp_cnt   (interp_cnt),
        .path_cnt     (path_cnt),
        .err_overflow (err_overflow),
        .commit_done  (commit_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] sels();
        return {sel1, sel2, sel3, sel4};
    endfunction

    task automatic checkModelState(input string tag);
        checkOutput({tag, "_interp_coe"}, 32'(interp_coe), 32'(expInterp));
        checkOutput({tag, "_coe"}, 32'(coe), 32'(expCoe));
        checkOutput({tag, "_interp_cnt"}, 32'(interp_cnt), 32'(expInterpCnt));
        checkOutput({tag, "_path_cnt"}, 32'(path_cnt), 32'(expPathCnt));
        checkOutput({tag, "_err"}, 32'(err_overflow), 32'(expErr));
    endtask

    task automatic resetModel();
        expInterpCnt = 0;
        expPathCnt   = 0;
        expInterp    = '0;
        expCoe       = '0;
        expErr       = 1'b0;
    endtask

    // Commit starting in an IDLE cycle.
    task automatic doCommit();
        checkOutput("c_pre_ready", 32'(commit_ready), 32'd1);
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        checkOutput("c_setup_sel", 32'(sels()), 32'h0);
        checkOutput("c_setup_ready", 32'(commit_ready), 32'd0);
        checkOutput("c_setup_done", 32'(commit_done), 32'd0);
        step();
        checkOutput("c_strobe_sel", 32'(sels()), 32'h3);
        checkOutput("c_strobe_done", 32'(commit_done), 32'd0);
        step();
        expInterpCnt = 0;
        expPathCnt   = 0;
        expErr       = 1'b0;
        checkOutput("c_done", 32'(commit_done), 32'd1);
        checkOutput("c_after_sel", 32'(sels()), 32'h0);
        checkOutput("c_after_ready", 32'(in_ready), 32'd1);
        checkModelState("c_after");
    endtask

    // Word starting in an IDLE cycle; optionally with commit_valid raised in
    // the same cycle, in which case the commit follows once IDLE returns.
    task automatic doWord(input logic kind, input logic [15:0] data,
                          input logic withCommit);
        logic room;
        room = kind ? (expPathCnt < 3) : (expInterpCnt < 12);
        checkOutput("w_pre_ready", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_kind      = kind;
        in_data      = data;
        commit_valid = withCommit;
        step();
        in_valid = 1'b0;
        in_kind  = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
        if (room) begin
            if (kind) expCoe = data;
            else      expInterp = data[9:0];
            checkOutput("w_setup_sel", 32'(sels()), 32'h0);
            checkOutput("w_setup_ready", 32'(in_ready), 32'd0);
            checkOutput("w_setup_cready", 32'(commit_ready), 32'd0);
            checkOutput("w_setup_interp", 32'(interp_coe), 32'(expInterp));
            checkOutput("w_setup_coe", 32'(coe), 32'(expCoe));
            step();
            if (kind) expPathCnt++;
            else      expInterpCnt++;
            checkOutput("w_strobe_sel", 32'(sels()), kind ? 32'h4 : 32'h8);
            checkOutput("w_strobe_ready", 32'(in_ready), 32'd0);
            checkModelState("w_strobe");
            step();
            checkOutput("w_after_sel", 32'(sels()), 32'h0);
            checkOutput("w_after_ready", 32'(in_ready), 32'd1);
            checkModelState("w_after");
        end else begin
            expErr = 1'b1;
            checkOutput("ovf_sel", 32'(sels()), 32'h0);
            checkOutput("ovf_ready", 32'(in_ready), 32'd1);
            checkModelState("ovf");
        end
        if (withCommit) doCommit();
    endtask

    // op: 0 tap word, 1 gain word, 2 commit, 3 word + commit together
    task automatic applyStimulus(input int op, input logic [15:0] data);
        case (op)
            0: doWord(1'b0, data, 1'b0);
            1: doWord(1'b1, data, 1'b0);
            2: doCommit();
            default: doWord(data[15], data, 1'b1);
        endcase
    endtask

    initial begin
        Reset        = 1'b1;
        in_valid     = 1'b0;
        in_kind      = 1'b0;
        in_data      = '0;
        commit_valid = 1'b0;
        resetModel();
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b0;
        checkOutput("rst_sel", 32'(sels()), 32'h0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_cready", 32'(commit_ready), 32'd1);
        checkOutput("rst_done", 32'(commit_done), 32'd0);
        checkModelState("rst");

        // Fill the tap chain, then overflow it
        for (int i = 1; i <= 12; i++) applyStimulus(0, 16'(i));
        checkOutput("full_interp_cnt", 32'(interp_cnt), 32'd12);
        applyStimulus(0, 16'h03FF);
        checkOutput("ovf_interp_hold", 32'(interp_coe), 32'h00C);

        // Gains then commit
        applyStimulus(1, 16'h3C00);
        applyStimulus(1, 16'h4000);
        applyStimulus(1, 16'h4200);
        applyStimulus(2, 16'h0);

        // Word and commit raised together
        doWord(1'b0, 16'h0155, 1'b1);

        // Reset during W_STROBE
        checkOutput("rs_pre_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_kind  = 1'b0;
        in_data  = 16'h0077;
        step();
        in_valid = 1'b0;
        step();
        checkOutput("rs_strobe_sel", 32'(sels()), 32'h8);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        resetModel();
        checkOutput("rs_after_sel", 32'(sels()), 32'h0);
        checkOutput("rs_after_ready", 32'(in_ready), 32'd1);
        checkModelState("rs_after");
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rs_quiet_sel", 32'(sels()), 32'h0);
        end

        // Randomized operations
        for (int n = 0; n < 120; n++) begin
            int r;
            int op;
            r = $urandom_range(0, 9);
            op = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            applyStimulus(op, 16'($urandom));
            repeat ($urandom_range(0, 2)) begin
                step();
                checkOutput("gap_sel", 32'(sels()), 32'h0);
                checkOutput("gap_ready", 32'(in_ready), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
